// File: rtl/norflash_rd.sv
// Read-only controller for asynchronous parallel NOR flash (8- or 16-bit), returns 32-bit big-endian words.
// Latency: N*RD_CYCLES edges from accept to rd_ack (N = 32/FLASH_DW); with NORFLASH_RD_PAGE_MODE_EN,
//          RD_CYCLES + (N-1)*PAGE_CYCLES. busy drops one edge after rd_ack.
// Backpressure: rd_stb is only sampled while busy=0; requests seen while busy are dropped, not queued.
//
// Ports:
//   sys_clk, sys_rst_n      clock, asynchronous active-low reset
//   rd_stb, rd_adr          read request and byte address (bits [1:0] ignored)
//   rd_dat, rd_ack, busy    assembled word, one-cycle completion pulse, controller-not-idle
//   flash_adr, flash_d      flash address (flash units) and data
//   flash_ce_n, flash_oe_n  active-low chip/output enables
// Optional: define NORFLASH_RD_PAGE_MODE_EN to use PAGE_CYCLES for beats 1..N-1.
module norflash_rd #(
    parameter int ADR_WIDTH   = 24,
    parameter int FLASH_DW    = 8,
    parameter int RD_CYCLES   = 6,
    parameter int PAGE_CYCLES = 2,
    localparam int FA         = (FLASH_DW == 16) ? ADR_WIDTH - 1 : ADR_WIDTH
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst_n,
    input  logic                 rd_stb,
    input  logic [ADR_WIDTH-1:0] rd_adr,
    output logic [31:0]          rd_dat,
    output logic                 rd_ack,
    output logic                 busy,
    output logic [FA-1:0]        flash_adr,
    input  logic [FLASH_DW-1:0]  flash_d,
    output logic                 flash_ce_n,
    output logic                 flash_oe_n
);

    localparam int N      = 32 / FLASH_DW;
    localparam int MAXCYC = (RD_CYCLES > PAGE_CYCLES) ? RD_CYCLES : PAGE_CYCLES;
    localparam int CW     = (MAXCYC > 1) ? $clog2(MAXCYC) : 1;

    localparam logic [CW-1:0] RD_RELOAD   = CW'(RD_CYCLES - 1);
`ifdef NORFLASH_RD_PAGE_MODE_EN
    // Later beats stay inside the open page, so they only need the shorter page access time.
    localparam logic [CW-1:0] BEAT_RELOAD = CW'(PAGE_CYCLES - 1);
`else
    localparam logic [CW-1:0] BEAT_RELOAD = CW'(RD_CYCLES - 1);
`endif
    localparam logic [1:0]    LAST_BEAT   = 2'(N - 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

    state_t          r_state,  w_state;
    logic [1:0]      r_beat,   w_beat;
    logic [CW-1:0]   r_wait,   w_wait;
    logic [FA-1:0]   r_adr,    w_adr;
    logic [31:0]     r_shift,  w_shift;
    logic [31:0]     r_dat,    w_dat;
    logic            r_ack,    w_ack;
    logic            r_ce_n,   w_ce_n;
    logic            r_oe_n,   w_oe_n;

    logic [ADR_WIDTH-1:0] w_word_adr;
    logic [FA-1:0]        w_first_adr;
    logic [31:0]          w_shift_in;
    logic                 w_unused_adr;

    // Word-align, then convert bytes to flash units (halfwords drop one more bit).
    assign w_word_adr   = {rd_adr[ADR_WIDTH-1:2], 2'b00};
    assign w_first_adr  = FA'(w_word_adr >> (FLASH_DW / 16));
    assign w_unused_adr = &{1'b0, rd_adr[1:0]};

    // Earlier beats shift toward the MSBs, so beat 0 ends up in rd_dat[31:32-FLASH_DW].
    assign w_shift_in = {r_shift[31-FLASH_DW:0], flash_d};

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state <= S_IDLE;
            r_beat  <= '0;
            r_wait  <= '0;
            r_adr   <= '0;
            r_shift <= '0;
            r_dat   <= '0;
            r_ack   <= 1'b0;
            r_ce_n  <= 1'b1;
            r_oe_n  <= 1'b1;
        end else begin
            r_state <= w_state;
            r_beat  <= w_beat;
            r_wait  <= w_wait;
            r_adr   <= w_adr;
            r_shift <= w_shift;
            r_dat   <= w_dat;
            r_ack   <= w_ack;
            r_ce_n  <= w_ce_n;
            r_oe_n  <= w_oe_n;
        end
    end

    always_comb begin
        w_state = r_state;
        w_beat  = r_beat;
        w_wait  = r_wait;
        w_adr   = r_adr;
        w_shift = r_shift;
        w_dat   = r_dat;
        w_ack   = 1'b0;
        w_ce_n  = r_ce_n;
        w_oe_n  = r_oe_n;
        case (r_state)
            S_IDLE: begin
                if (rd_stb) begin
                    w_adr   = w_first_adr;
                    w_ce_n  = 1'b0;
                    w_oe_n  = 1'b0;
                    w_wait  = RD_RELOAD;
                    w_beat  = '0;
                    w_state = S_WAIT;
                end
            end
            S_WAIT: begin
                if (r_wait != '0) begin
                    w_wait = r_wait - 1'b1;
                end else begin
                    w_shift = w_shift_in;
                    if (r_beat != LAST_BEAT) begin
                        // Aligned start guarantees this increment never leaves the word group.
                        w_beat = r_beat + 1'b1;
                        w_adr  = r_adr + 1'b1;
                        w_wait = BEAT_RELOAD;
                    end else begin
                        w_dat   = w_shift_in;
                        w_ack   = 1'b1;
                        w_ce_n  = 1'b1;
                        w_oe_n  = 1'b1;
                        w_state = S_DONE;
                    end
                end
            end
            S_DONE: begin
                w_state = S_IDLE;
            end
            default: begin
                w_state = S_IDLE;
            end
        endcase
    end

    assign rd_dat     = r_dat;
    assign rd_ack     = r_ack;
    assign busy       = (r_state != S_IDLE);
    assign flash_adr  = r_adr;
    assign flash_ce_n = r_ce_n;
    assign flash_oe_n = r_oe_n;

endmodule

// File: tb/tb_norflash_rd.sv
module tb_norflash_rd;

`ifdef NORFLASH_RD_PAGE_MODE_EN
    localparam bit PAGE = 1'b1;
`else
    localparam bit PAGE = 1'b0;
`endif
    // Hand-computed latencies (accept edge to rd_ack edge) for RD_CYCLES=6, PAGE_CYCLES=2.
    localparam int L8  = PAGE ? 12 : 24;
    localparam int L16 = PAGE ? 8  : 12;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    int          cyc = 0;

    logic        stb8 = 1'b0;
    logic [23:0] adr8 = '0;
    logic [31:0] dat8;
    logic        ack8, busy8, ce8, oe8;
    logic [23:0] fadr8;
    logic [7:0]  fd8;

    logic        stb16 = 1'b0;
    logic [23:0] adr16 = '0;
    logic [31:0] dat16;
    logic        ack16, busy16, ce16, oe16;
    logic [22:0] fadr16;
    logic [15:0] fd16;

    int n_chk = 0;
    int n_err = 0;

    typedef struct {
        logic [31:0] dat;
        int          ack_cyc;
    } exp_t;
    exp_t q8[$];
    exp_t q16[$];

    norflash_rd #(.FLASH_DW(8)) u8 (
        .sys_clk(clk), .sys_rst_n(rst_n), .rd_stb(stb8), .rd_adr(adr8),
        .rd_dat(dat8), .rd_ack(ack8), .busy(busy8), .flash_adr(fadr8),
        .flash_d(fd8), .flash_ce_n(ce8), .flash_oe_n(oe8)
    );

    norflash_rd #(.FLASH_DW(16)) u16 (
        .sys_clk(clk), .sys_rst_n(rst_n), .rd_stb(stb16), .rd_adr(adr16),
        .rd_dat(dat16), .rd_ack(ack16), .busy(busy16), .flash_adr(fadr16),
        .flash_d(fd16), .flash_ce_n(ce16), .flash_oe_n(oe16)
    );

    // Flash models: 8-bit returns low address byte; 16-bit has DEAD/BEEF at 0x80/0x81.
    assign fd8  = fadr8[7:0];
    assign fd16 = (fadr16 == 23'h80) ? 16'hDEAD :
                  (fadr16 == 23'h81) ? 16'hBEEF : fadr16[15:0];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Edge offset (from accept) at which flash_adr presents beat b.
    function automatic int step8(input int b);
        if (b == 0) return 0;
        return PAGE ? (6 + 2 * (b - 1)) : (6 * b);
    endfunction

    // Scoreboard monitor: every rd_ack pops one expected word and checks data and timing.
    always @(negedge clk) begin
        exp_t e;
        if (ack8) begin
            if (q8.size() == 0) check("ack8_unexpected", 32'd1, 32'd0);
            else begin
                e = q8.pop_front();
                check("dat8", dat8, e.dat);
                check("ack8_cycle", cyc, e.ack_cyc);
                check("busy8_at_ack", {31'd0, busy8}, 32'd1);
            end
        end
        if (ack16) begin
            if (q16.size() == 0) check("ack16_unexpected", 32'd1, 32'd0);
            else begin
                e = q16.pop_front();
                check("dat16", dat16, e.dat);
                check("ack16_cycle", cyc, e.ack_cyc);
            end
        end
    end

    task automatic wait_to(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic wait_idle8();
        int n = 0;
        while (busy8 && n < 100) begin @(negedge clk); n++; end
        if (busy8) check("busy8_timeout", 32'd1, 32'd0);
    endtask

    task automatic wait_idle16();
        int n = 0;
        while (busy16 && n < 100) begin @(negedge clk); n++; end
        if (busy16) check("busy16_timeout", 32'd1, 32'd0);
    endtask

    // Drive a one-cycle strobe on an idle controller; returns accept edge k (cyc at return == k).
    task automatic issue8(input logic [23:0] a, input logic [31:0] exp, input bit push, output int k);
        exp_t e;
        @(negedge clk);
        stb8 = 1'b1;
        adr8 = a;
        k = cyc + 1;
        if (push) begin
            e.dat = exp; e.ack_cyc = k + L8;
            q8.push_back(e);
        end
        @(negedge clk);
        stb8 = 1'b0;
    endtask

    task automatic issue16(input logic [23:0] a, input logic [31:0] exp, output int k);
        exp_t e;
        @(negedge clk);
        stb16 = 1'b1;
        adr16 = a;
        k = cyc + 1;
        e.dat = exp; e.ack_cyc = k + L16;
        q16.push_back(e);
        @(negedge clk);
        stb16 = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int ce_low;

        // 1. Reset / idle
        repeat (10) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_ack", {31'd0, ack8}, 32'd0);
        check("rst_busy", {31'd0, busy8}, 32'd0);
        check("rst_ce_oe", {30'd0, ce8, oe8}, 32'd3);
        check("rst_fadr", {8'd0, fadr8}, 32'd0);
        check("rst_dat", dat8, 32'd0);
        check("rst_busy16", {31'd0, busy16}, 32'd0);
        ce_low = 0;
        repeat (50) begin
            @(negedge clk);
            if (!ce8 || !ce16) ce_low++;
        end
        check("idle_ce_low_cycles", ce_low, 32'd0);

        // 2. 8-bit read of 0x6 with address stepping; 4. a strobe while busy is dropped.
        issue8(24'h000006, 32'h04050607, 1'b1, k);
        check("rd8_ce_on", {31'd0, ce8}, 32'd0);
        for (int b = 0; b < 4; b++) begin
            wait_to(k + step8(b));
            check("rd8_fadr_step", {8'd0, fadr8}, 32'h4 + b);
            if (b == 1) begin
                stb8 = 1'b1; adr8 = 24'h20;
                @(negedge clk);
                stb8 = 1'b0;
            end
        end
        wait_idle8();
        check("rd8_ce_off", {31'd0, ce8}, 32'd1);
        repeat (3) @(negedge clk);
        check("rd8_dat_hold", dat8, 32'h04050607);
        issue8(24'h000020, 32'h20212223, 1'b1, k);
        wait_idle8();

        // 3. 16-bit read: words 0x80/0x81
        issue16(24'h000100, 32'hDEADBEEF, k);
        check("rd16_fadr0", {9'd0, fadr16}, 32'h80);
        wait_to(k + 6);
        check("rd16_fadr1", {9'd0, fadr16}, 32'h81);
        wait_idle16();

        // 5. Reset in the middle of an 8-bit read
        issue8(24'h000000, 32'h0, 1'b0, k);
        wait_to(k + 10);
        check("mid_busy_before", {31'd0, busy8}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_ce_oe", {30'd0, ce8, oe8}, 32'd3);
        check("mid_rst_busy", {31'd0, busy8}, 32'd0);
        check("mid_rst_ack", {31'd0, ack8}, 32'd0);
        check("mid_rst_fadr", {8'd0, fadr8}, 32'd0);
        check("mid_rst_dat16", dat16, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        issue8(24'h000000, 32'h00010203, 1'b1, k);
        wait_idle8();

        // 6. Read of 0x4 (page-mode timing when the macro is defined)
        issue8(24'h000004, 32'h04050607, 1'b1, k);
        for (int b = 0; b < 4; b++) begin
            wait_to(k + step8(b));
            check("rd4_fadr_step", {8'd0, fadr8}, 32'h4 + b);
        end
        wait_idle8();

        repeat (5) @(negedge clk);
        check("q8_drained", q8.size(), 32'd0);
        check("q16_drained", q16.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
